// File: rtl/seg_scan_ctrl_if.sv
// Update handshake and payload bundle for seg_scan_ctrl.
// master drives updates (host side), slave is the display controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic                    upd_raw;
  logic [VAL_W-1:0]        bin_val;
  logic [4*NUM_DIGITS-1:0] nib_val;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (
    output upd_valid, upd_raw, bin_val, nib_val, blank_lz, dp_mask, blink_mask,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_raw, bin_val, nib_val, blank_lz, dp_mask, blink_mask,
    output upd_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment driver: double-dabble BCD or raw hex updates, scanned digit output.
// Optional blinking is compiled in when the SEG_BLINK_EN macro is defined.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int VAL_W        = 14,
  parameter bit SEL_ACT_HIGH = 1'b1,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter int BLINK_HZ     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_ctrl_if.slave        upd,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic [7:0]            seg_data
);
  // Decimal digits needed to hold 2^VAL_W-1 (log10(2) ~ 0.30103).
  localparam int BCD_DIGITS = (VAL_W * 30103) / 100000 + 1;
  localparam int BCD_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int BCD_W      = 4 * BCD_N;
  localparam int BC_W       = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int SCAN_DIV   = CLK_FREQ / (SCAN_HZ * NUM_DIGITS);
  localparam int SC_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [BC_W-1:0]       LAST_BIT  = BC_W'(VAL_W - 1);
  localparam logic [SC_W-1:0]       SCAN_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = SEL_ACT_HIGH ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};
  localparam logic [7:0]            SEG_OFF   = SEG_ACT_HIGH ? 8'h00 : 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

  state_t                           state_q, state_d;
  logic [BC_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic                             raw_q, raw_d, blank_lz_q, blank_lz_d;
  logic [NUM_DIGITS-1:0]            dp_q, dp_d;
  logic [4*NUM_DIGITS-1:0]          nib_q, nib_d;
  logic [VAL_W-1:0]                 bin_q, bin_d;
  logic [BCD_W-1:0]                 bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0][3:0]       disp_nib_q, disp_nib_d;
  logic [NUM_DIGITS-1:0]            disp_blank_q, disp_blank_d, disp_dp_q, disp_dp_d;
  logic                             overflow_q, overflow_d;
  logic [SC_W-1:0]                  scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]                 scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0]            seg_sel_q, seg_sel_d;
  logic [7:0]                       seg_data_q, seg_data_d;

  logic                             accept, commit, bcd_ovf, blink_off, unused_ok;
  logic [BCD_W-1:0]                 dab;
  logic [NUM_DIGITS:0]              hi_zero;
  logic [NUM_DIGITS-1:0]            new_blank;

  assign accept        = (state_q == ST_IDLE) && upd.upd_valid;
  assign commit        = (state_q == ST_COMMIT);
  assign upd.upd_ready = (state_q == ST_IDLE);

  // Add-3 correction on every BCD digit before the shift.
  for (genvar gi = 0; gi < BCD_N; gi++) begin : g_dab
    assign dab[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
  end

  if (BCD_N > NUM_DIGITS) begin : g_ovf
    assign bcd_ovf = |bcd_q[BCD_W-1:4*NUM_DIGITS];
  end else begin : g_no_ovf
    assign bcd_ovf = 1'b0;
  end

  // hi_zero[i]: digit i and everything above it are zero.
  assign hi_zero[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign hi_zero[gi] = hi_zero[gi+1] && (bcd_q[4*gi +: 4] == 4'd0);
    if (gi == 0) begin : g_d0
      assign new_blank[gi] = 1'b0;
    end else begin : g_dn
      assign new_blank[gi] = !raw_q && blank_lz_q && !bcd_ovf && hi_zero[gi];
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    raw_d        = raw_q;
    blank_lz_d   = blank_lz_q;
    dp_d         = dp_q;
    nib_d        = nib_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    disp_nib_d   = disp_nib_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (upd.upd_valid) begin
          raw_d      = upd.upd_raw;
          blank_lz_d = upd.blank_lz;
          dp_d       = upd.dp_mask;
          nib_d      = upd.nib_val;
          bin_d      = upd.bin_val;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          state_d    = upd.upd_raw ? ST_COMMIT : ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_d     = {dab[BCD_W-2:0], bin_q[VAL_W-1]};
        bin_d     = bin_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_nib_d   = raw_q ? nib_q : bcd_q[4*NUM_DIGITS-1:0];
        disp_blank_d = new_blank;
        disp_dp_d    = dp_q;
        overflow_d   = !raw_q && bcd_ovf;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Scan timing and output pattern; polarity is folded in last.
  always_comb begin
    logic [7:0]            act;
    logic [NUM_DIGITS-1:0] one_hot;
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
    one_hot             = '0;
    one_hot[scan_idx_q] = 1'b1;
    act = {disp_dp_q[scan_idx_q], overflow_q ? 7'h40 : hex_glyph(disp_nib_q[scan_idx_q])};
    if (disp_blank_q[scan_idx_q] || blink_off) act = 8'h00;
    seg_sel_d  = SEL_ACT_HIGH ? one_hot : ~one_hot;
    seg_data_d = SEG_ACT_HIGH ? act : ~act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      raw_q        <= 1'b0;
      blank_lz_q   <= 1'b0;
      dp_q         <= '0;
      nib_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      disp_nib_q   <= '0;
      disp_blank_q <= '0;
      disp_dp_q    <= '0;
      overflow_q   <= 1'b0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      seg_sel_q    <= SEL_OFF;
      seg_data_q   <= SEG_OFF;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      raw_q        <= raw_d;
      blank_lz_q   <= blank_lz_d;
      dp_q         <= dp_d;
      nib_q        <= nib_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      disp_nib_q   <= disp_nib_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      overflow_q   <= overflow_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      seg_sel_q    <= seg_sel_d;
      seg_data_q   <= seg_data_d;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BK_W-1:0] BLINK_LAST = BK_W'(BLINK_DIV - 1);

  logic [BK_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d, disp_blink_q, disp_blink_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    blink_d       = accept ? upd.blink_mask : blink_q;
    disp_blink_d  = commit ? blink_q : disp_blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = !blink_phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      blink_q       <= '0;
      disp_blink_q  <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      blink_q       <= blink_d;
      disp_blink_q  <= disp_blink_d;
    end
  end

  assign blink_off = blink_phase_q && disp_blink_q[scan_idx_q];
  assign unused_ok = dab[BCD_W-1] ^ hi_zero[0];
`else
  assign blink_off = 1'b0;
  assign unused_ok = ^{dab[BCD_W-1], hi_zero[0], upd.blink_mask, accept, commit, BLINK_HZ != 0};
`endif

  assign overflow = overflow_q;
  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;
endmodule
